sync_fifo_flex: RTL and testbench

//  Parametrised single-clock FIFO. Successor to the fixed 8x8 FIFO. Adds configurable width and depth,

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/sync_fifo_flex.sv | 108 ++++++++++
 tb/tb_sync_fifo_flex.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and parameter sanity helpers for the flexible FIFO
package fifo_pkg;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit thresholds_ok(input int depth, input int af, input int ae);
      return (ae >= 0) && (ae < af) && (af <= depth);
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DATA_W x DEPTH storage, synchronous write, asynchronous read
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int AW     = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   // Contents are deliberately not reset; only pointers define what is valid.
   logic [DATA_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with thresholds, fill level, sticky errors and optional FWFT
module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [clog2(DEPTH):0] count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DATA_W < 1 || !is_pow2(DEPTH) || !thresholds_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_check
      $error("sync_fifo_flex: illegal DATA_W/DEPTH/threshold parameters");
   end

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   // A full FIFO rejects writes even when a read frees a slot in the same cycle.
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A new error event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full)      overflow <= 1'b1;
         else if (err_clr)       overflow <= 1'b0;
         if (rd_en && empty)     underflow <= 1'b1;
         else if (err_clr)       underflow <= 1'b0;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is shown while non-empty; forced to zero when empty so reset reads as 0.
      assign rd_data  = empty ? '0 : mem_rdata;
      assign rd_valid = ~empty;
   end else begin : g_reg_read
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - directed bench driving a registered-read and an FWFT instance in lockstep
module tb_sync_fifo_flex;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic       err_clr;

   logic       r_full, r_afull, r_empty, r_aempty, r_valid, r_ovf, r_unf;
   logic [7:0] r_data;
   logic [3:0] r_count;
   logic       f_full, f_afull, f_empty, f_aempty, f_valid, f_ovf, f_unf;
   logic [7:0] f_data;
   logic [3:0] f_count;

   int checks;
   int errors;
   logic [7:0] model_q[$];
   logic [7:0] exp;

   sync_fifo_flex #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_reg (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(r_full),
      .almost_full(r_afull), .rd_en(rd_en), .rd_data(r_data), .rd_valid(r_valid),
      .empty(r_empty), .almost_empty(r_aempty), .count(r_count), .overflow(r_ovf),
      .underflow(r_unf), .err_clr(err_clr)
   );

   sync_fifo_flex #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_fwft (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
      .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_data), .rd_valid(f_valid),
      .empty(f_empty), .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf),
      .underflow(f_unf), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
      step(); step();
      checks++; if (r_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", r_count); end
      checks++; if ({r_empty, r_aempty, r_full, r_afull} !== 4'b1100) begin errors++; $display("FAIL reset_flags_reg: got %b expected 1100", {r_empty, r_aempty, r_full, r_afull}); end
      checks++; if ({f_empty, f_aempty, f_full, f_afull} !== 4'b1100) begin errors++; $display("FAIL reset_flags_fwft: got %b expected 1100", {f_empty, f_aempty, f_full, f_afull}); end
      checks++; if ({r_valid, f_valid, r_ovf, r_unf, f_ovf, f_unf} !== 6'b0) begin errors++; $display("FAIL reset_valid_err: got %b expected 000000", {r_valid, f_valid, r_ovf, r_unf, f_ovf, f_unf}); end
      checks++; if (r_data !== 8'h00 || f_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h/%h expected 00/00", r_data, f_data); end
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         push(8'(8'h11 * (i + 1)));
         checks++; if (r_count !== 4'(i + 1) || f_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d/%0d expected %0d", i, r_count, f_count, i + 1); end
         checks++; if (r_full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, r_full, (i == 7)); end
         if (i == 0) begin
            checks++; if (f_valid !== 1'b1 || f_data !== 8'h11) begin errors++; $display("FAIL fwft_first_word: got valid %b data %h expected 1 11", f_valid, f_data); end
         end
      end
      for (int i = 0; i < 8; i++) begin
         exp = 8'(8'h11 * (i + 1));
         checks++; if (f_data !== exp) begin errors++; $display("FAIL fwft_head[%0d]: got %h expected %h", i, f_data, exp); end
         pop();
         checks++; if (r_valid !== 1'b1 || r_data !== exp) begin errors++; $display("FAIL reg_read[%0d]: got valid %b data %h expected 1 %h", i, r_valid, r_data, exp); end
         checks++; if (r_count !== 4'(7 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, r_count, 7 - i); end
         checks++; if (r_empty !== (i == 7) || f_valid !== (i != 7)) begin errors++; $display("FAIL drain_empty[%0d]: got empty %b fvalid %b expected %b %b", i, r_empty, f_valid, (i == 7), (i != 7)); end
      end
      step();
      checks++; if (r_valid !== 1'b0 || r_data !== 8'h88) begin errors++; $display("FAIL reg_valid_pulse: got valid %b data %h expected 0 88", r_valid, r_data); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)));
      push(8'hFF);
      checks++; if (r_count !== 4'd8 || r_full !== 1'b1) begin errors++; $display("FAIL ovf_count: got %0d full %b expected 8 1", r_count, r_full); end
      checks++; if (r_ovf !== 1'b1 || f_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b/%b expected 1/1", r_ovf, f_ovf); end
      err_clr = 1'b1; step(); err_clr = 1'b0;
      checks++; if (r_ovf !== 1'b0 || f_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b/%b expected 0/0", r_ovf, f_ovf); end
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++; if (r_count !== 4'd7 || r_ovf !== 1'b1 || r_data !== 8'h11) begin errors++; $display("FAIL full_wr_rd: got count %0d ovf %b data %h expected 7 1 11", r_count, r_ovf, r_data); end
      for (int i = 1; i < 8; i++) begin
         exp = 8'(8'h11 * (i + 1));
         checks++; if (f_data !== exp) begin errors++; $display("FAIL ovf_fwft_contents[%0d]: got %h expected %h", i, f_data, exp); end
         pop();
         checks++; if (r_data !== exp) begin errors++; $display("FAIL ovf_contents[%0d]: got %h expected %h", i, r_data, exp); end
      end
      err_clr = 1'b1; step(); err_clr = 1'b0;
   endtask

   task automatic test_underflow();
      pop();
      checks++; if (r_unf !== 1'b1 || f_unf !== 1'b1) begin errors++; $display("FAIL unf_set: got %b/%b expected 1/1", r_unf, f_unf); end
      checks++; if (r_valid !== 1'b0 || r_count !== 4'd0 || f_valid !== 1'b0) begin errors++; $display("FAIL unf_state: got rvalid %b count %0d fvalid %b expected 0 0 0", r_valid, r_count, f_valid); end
      err_clr = 1'b1; step(); err_clr = 1'b0;
      checks++; if (r_unf !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", r_unf); end
      err_clr = 1'b1; rd_en = 1'b1; step(); err_clr = 1'b0; rd_en = 1'b0;
      checks++; if (r_unf !== 1'b1 || f_unf !== 1'b1) begin errors++; $display("FAIL unf_set_wins: got %b/%b expected 1/1", r_unf, f_unf); end
      err_clr = 1'b1; step(); err_clr = 1'b0;
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3C;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++; if (r_count !== 4'd1 || r_unf !== 1'b1 || r_valid !== 1'b0) begin errors++; $display("FAIL empty_wr_rd: got count %0d unf %b valid %b expected 1 1 0", r_count, r_unf, r_valid); end
      checks++; if (f_data !== 8'h3C) begin errors++; $display("FAIL empty_wr_rd_fwft: got %h expected 3c", f_data); end
      pop();
      checks++; if (r_data !== 8'h3C || r_empty !== 1'b1) begin errors++; $display("FAIL empty_wr_rd_data: got %h empty %b expected 3c 1", r_data, r_empty); end
      err_clr = 1'b1; step(); err_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      model_q.delete();
      for (int i = 0; i < 4; i++) begin
         push(8'(8'hA0 + i));
         model_q.push_back(8'(8'hA0 + i));
      end
      for (int k = 0; k < 10; k++) begin
         exp = model_q.pop_front();
         checks++; if (f_data !== exp) begin errors++; $display("FAIL b2b_fwft[%0d]: got %h expected %h", k, f_data, exp); end
         wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'hB0 + k);
         step();
         model_q.push_back(8'(8'hB0 + k));
         checks++; if (r_count !== 4'd4 || r_data !== exp || r_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d]: got count %0d data %h valid %b expected 4 %h 1", k, r_count, r_data, r_valid, exp); end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp = model_q.pop_front();
         pop();
         checks++; if (r_data !== exp) begin errors++; $display("FAIL b2b_drain[%0d]: got %h expected %h", i, r_data, exp); end
      end
   endtask

   task automatic test_thresholds();
      for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
      checks++; if (r_afull !== 1'b0 || r_aempty !== 1'b0 || r_count !== 4'd5) begin errors++; $display("FAIL thr_count5: got af %b ae %b count %0d expected 0 0 5", r_afull, r_aempty, r_count); end
      push(8'h55);
      checks++; if (r_afull !== 1'b1 || f_afull !== 1'b1) begin errors++; $display("FAIL thr_count6: got af %b/%b expected 1/1", r_afull, f_afull); end
      pop(); pop(); pop();
      checks++; if (r_count !== 4'd3 || r_aempty !== 1'b0 || r_afull !== 1'b0) begin errors++; $display("FAIL thr_count3: got count %0d ae %b af %b expected 3 0 0", r_count, r_aempty, r_afull); end
      pop();
      checks++; if (r_aempty !== 1'b1 || f_aempty !== 1'b1) begin errors++; $display("FAIL thr_count2: got ae %b/%b expected 1/1", r_aempty, f_aempty); end
      pop(); pop();
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
      checks++; if (r_count !== 4'd5 || r_data !== 8'h55) begin errors++; $display("FAIL pre_reset: got count %0d data %h expected 5 55", r_count, r_data); end
      reset = 1'b0;
      #2;
      checks++; if (r_count !== 4'd0 || f_count !== 4'd0 || r_empty !== 1'b1 || r_aempty !== 1'b1) begin errors++; $display("FAIL mid_reset_count: got %0d/%0d empty %b ae %b expected 0/0 1 1", r_count, f_count, r_empty, r_aempty); end
      checks++; if (r_data !== 8'h00 || f_data !== 8'h00 || f_valid !== 1'b0 || r_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %h/%h fvalid %b rvalid %b expected 00/00 0 0", r_data, f_data, f_valid, r_valid); end
      reset = 1'b1;
      step();
      push(8'hA5);
      checks++; if (f_data !== 8'hA5 || r_count !== 4'd1) begin errors++; $display("FAIL post_reset_fwft: got %h count %0d expected a5 1", f_data, r_count); end
      pop();
      checks++; if (r_data !== 8'hA5 || r_empty !== 1'b1) begin errors++; $display("FAIL post_reset_read: got %h empty %b expected a5 1", r_data, r_empty); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_thresholds();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
